// File: rtl/sram_cmd_engine_if.sv
// UART byte stream and SRAM driver signals seen by sram_cmd_engine.
// master is the engine side; slave is the uart/driver side.
interface sram_cmd_engine_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_write;
  logic [DATA_W-1:0] ram_data_read;
  logic              ram_re;
  logic              ram_start;
  logic              ram_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready, ram_data_read, ram_ready,
    output tx_data, tx_start, ram_address, ram_data_write, ram_re, ram_start
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, ram_data_read, ram_ready,
    input  tx_data, tx_start, ram_address, ram_data_write, ram_re, ram_start
  );
endinterface

// File: rtl/sram_cmd_engine.sv
// Serial SRAM command engine: 5-byte command frames in, SRAM driver accesses,
// 4-byte big-endian replies out, with bursts, frame timeout and sticky status.
module sram_cmd_engine #(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 8,
  parameter int LEN_W         = 16,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  sram_cmd_engine_if.master bus,
  output logic              busy,
  output logic [3:0]        status
);
  localparam int TO_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [7:0] CMD_ADDR       = 8'h01;
  localparam logic [7:0] CMD_LOAD       = 8'h02;
  localparam logic [7:0] CMD_WRITE      = 8'h03;
  localparam logic [7:0] CMD_READ       = 8'h04;
  localparam logic [7:0] CMD_READ_REQ   = 8'h05;
  localparam logic [7:0] CMD_COUNT      = 8'h06;
  localparam logic [7:0] CMD_BURST_READ = 8'h08;
  localparam logic [7:0] CMD_BURST_FILL = 8'h09;
  localparam logic [7:0] CMD_MODE       = 8'h0A;
  localparam logic [7:0] CMD_STATUS     = 8'h0B;

  // Start cycle plus two guard cycles during which ram_ready is not trusted.
  localparam logic [1:0] RAM_HOLD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_RAM_REQ  = 3'd2,
    S_RAM_WAIT = 3'd3,
    S_TX_LOAD  = 3'd4,
    S_TX_WAIT  = 3'd5
  } state_t;

  state_t            state_reg;
  logic              busy_reg;
  logic [2:0]        byte_cnt_reg;
  logic [7:0]        cmd_reg;
  logic [31:0]       arg_reg;
  logic [TO_W-1:0]   idle_cnt_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [31:0]       count_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [31:0]       reply_reg;
  logic [1:0]        tx_idx_reg;
  logic              tx_seen_low_reg;
  logic [1:0]        ram_hold_reg;
  logic              ram_re_reg;
  logic              ram_start_reg;
  logic              tx_start_reg;
  logic [7:0]        tx_data_reg;
  logic              mode_reg;

  logic              frame_expired;
  logic              rx_accept;
  logic              rx_drop;
  logic              frame_done;
  logic              cmd_known;
  logic [2:0]        status_set;
  logic              status_clr;
  logic [2:0]        sticky_flags;
  logic [LEN_W-1:0]  arg_len;

  assign frame_expired = (byte_cnt_reg != 3'd0) && (idle_cnt_reg == TO_W'(FRAME_TIMEOUT));
  assign rx_accept     = bus.rx_valid && !busy_reg;
  assign rx_drop       = bus.rx_valid && busy_reg;
  assign frame_done    = rx_accept && (byte_cnt_reg == 3'd4) && !frame_expired;
  assign arg_len       = arg_reg[LEN_W-1:0];

  // Frame assembly; a byte landing on the expiry cycle restarts the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt_reg <= 3'd0;
      cmd_reg      <= 8'h00;
      arg_reg      <= 32'h0;
      idle_cnt_reg <= '0;
    end else begin
      if (rx_accept || frame_expired) begin
        idle_cnt_reg <= '0;
      end else if (byte_cnt_reg != 3'd0) begin
        idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
      end
      if (rx_accept) begin
        if (frame_expired || byte_cnt_reg == 3'd0) begin
          cmd_reg      <= bus.rx_data;
          byte_cnt_reg <= 3'd1;
        end else begin
          arg_reg      <= {arg_reg[23:0], bus.rx_data};
          byte_cnt_reg <= (byte_cnt_reg == 3'd4) ? 3'd0 : byte_cnt_reg + 3'd1;
        end
      end else if (frame_expired) begin
        byte_cnt_reg <= 3'd0;
      end
    end
  end

  always_comb begin
    cmd_known = 1'b0;
    case (cmd_reg)
      CMD_ADDR, CMD_LOAD, CMD_WRITE, CMD_READ, CMD_READ_REQ, CMD_COUNT,
      CMD_BURST_READ, CMD_BURST_FILL, CMD_MODE, CMD_STATUS: cmd_known = 1'b1;
      default: cmd_known = 1'b0;
    endcase
  end

  assign status_set = {(state_reg == S_DECODE) && !cmd_known, frame_expired, rx_drop};
  assign status_clr = (state_reg == S_DECODE) && (cmd_reg == CMD_STATUS);

  // A set in the same cycle as a STATUS clear survives into the next report.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sticky
      logic flag_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          flag_reg <= 1'b0;
        end else begin
          flag_reg <= status_set[gi] | (flag_reg & ~status_clr);
        end
      end
      assign sticky_flags[gi] = flag_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_reg <= 1'b0;
    end else if (state_reg == S_DECODE && cmd_reg == CMD_MODE) begin
      mode_reg <= arg_reg[0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= S_IDLE;
      busy_reg        <= 1'b0;
      address_reg     <= '0;
      wdata_reg       <= '0;
      rdata_reg       <= '0;
      count_reg       <= 32'h0;
      len_reg         <= '0;
      reply_reg       <= 32'h0;
      tx_idx_reg      <= 2'd0;
      tx_seen_low_reg <= 1'b0;
      ram_hold_reg    <= 2'd0;
      ram_re_reg      <= 1'b0;
      ram_start_reg   <= 1'b0;
      tx_start_reg    <= 1'b0;
      tx_data_reg     <= 8'h00;
    end else begin
      ram_start_reg <= 1'b0;
      tx_start_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (frame_done) begin
            state_reg <= S_DECODE;
            busy_reg  <= 1'b1;
          end
        end

        S_DECODE: begin
          state_reg <= S_TX_LOAD;
          reply_reg <= arg_reg;
          case (cmd_reg)
            CMD_ADDR: address_reg <= arg_reg[ADDR_W-1:0];
            CMD_LOAD: wdata_reg <= arg_reg[DATA_W-1:0];
            CMD_WRITE: begin
              reply_reg <= 32'h3;
              state_reg <= S_RAM_REQ;
            end
            CMD_READ: reply_reg <= 32'(rdata_reg);
            CMD_READ_REQ: begin
              reply_reg <= 32'h5;
              state_reg <= S_RAM_REQ;
            end
            CMD_COUNT: begin
              reply_reg <= count_reg;
              count_reg <= count_reg + 32'd1;
            end
            CMD_BURST_READ, CMD_BURST_FILL: begin
              // Fill replies N at the end; a read burst overwrites this per word.
              len_reg   <= arg_len;
              reply_reg <= 32'(arg_len);
              if (arg_len != '0) begin
                state_reg <= S_RAM_REQ;
              end
            end
            CMD_MODE: reply_reg <= arg_reg;
            CMD_STATUS: reply_reg <= {28'h0, status};
            default: reply_reg <= {24'h0, cmd_reg};
          endcase
        end

        S_RAM_REQ: begin
          if (bus.ram_ready) begin
            ram_start_reg <= 1'b1;
            ram_re_reg    <= (cmd_reg == CMD_READ_REQ) || (cmd_reg == CMD_BURST_READ);
            ram_hold_reg  <= RAM_HOLD;
            state_reg     <= S_RAM_WAIT;
          end
        end

        S_RAM_WAIT: begin
          if (ram_hold_reg != 2'd0) begin
            ram_hold_reg <= ram_hold_reg - 2'd1;
          end else if (bus.ram_ready) begin
            state_reg <= S_TX_LOAD;
            case (cmd_reg)
              CMD_WRITE: begin
                if (mode_reg) address_reg <= address_reg + ADDR_W'(1);
              end
              CMD_READ_REQ: begin
                rdata_reg <= bus.ram_data_read;
                if (mode_reg) address_reg <= address_reg + ADDR_W'(1);
              end
              CMD_BURST_READ: begin
                rdata_reg   <= bus.ram_data_read;
                reply_reg   <= 32'(bus.ram_data_read);
                address_reg <= address_reg + ADDR_W'(1);
                len_reg     <= len_reg - LEN_W'(1);
              end
              CMD_BURST_FILL: begin
                address_reg <= address_reg + ADDR_W'(1);
                len_reg     <= len_reg - LEN_W'(1);
                if (len_reg != LEN_W'(1)) state_reg <= S_RAM_REQ;
              end
              default: ;
            endcase
          end
        end

        S_TX_LOAD: begin
          if (bus.tx_ready) begin
            tx_start_reg    <= 1'b1;
            tx_data_reg     <= reply_reg[31:24];
            reply_reg       <= {reply_reg[23:0], 8'h00};
            tx_seen_low_reg <= 1'b0;
            state_reg       <= S_TX_WAIT;
          end
        end

        S_TX_WAIT: begin
          // uart_tx may keep ready high briefly after a pulse; wait for a low first.
          if (!bus.tx_ready) begin
            tx_seen_low_reg <= 1'b1;
          end else if (tx_seen_low_reg) begin
            if (tx_idx_reg == 2'd3) begin
              tx_idx_reg <= 2'd0;
              if (cmd_reg == CMD_BURST_READ && len_reg != '0) begin
                state_reg <= S_RAM_REQ;
              end else begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              tx_idx_reg <= tx_idx_reg + 2'd1;
              state_reg  <= S_TX_LOAD;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data        = tx_data_reg;
  assign bus.tx_start       = tx_start_reg;
  assign bus.ram_address    = address_reg;
  assign bus.ram_data_write = wdata_reg;
  assign bus.ram_re         = ram_re_reg;
  assign bus.ram_start      = ram_start_reg;
  assign busy               = busy_reg;
  assign status             = {mode_reg, sticky_flags};
endmodule

// File: tb/tb_sram_cmd_engine.sv
// Directed bench for sram_cmd_engine with behavioural uart_tx and SRAM driver models.
module tb_sram_cmd_engine;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 16;
  localparam int FT     = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       busy;
  logic [3:0] status;

  sram_cmd_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_cmd_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FRAME_TIMEOUT(FT)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .status(status)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatch = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // uart_tx model: ready drops two cycles after a pulse, stays low four cycles.
  logic [7:0] tx_q[$];
  int tx_ph = 0;
  int tx_viol = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      tx_ph = 0;
      bus.tx_ready = 1'b1;
    end else begin
      if (bus.tx_start) begin
        if (!bus.tx_ready || tx_ph != 0) tx_viol++;
        tx_q.push_back(bus.tx_data);
        tx_ph = 1;
      end else if (tx_ph != 0) begin
        tx_ph++;
        if (tx_ph == 7) tx_ph = 0;
      end
      bus.tx_ready = (tx_ph < 3);
    end
  end

  // SRAM driver model: memory preset to mem[a] = a[7:0], access takes 5 cycles.
  logic [7:0]  mem [0:8191];
  logic        mem_init = 1'b0;
  int          ram_ph = 0;
  int          ram_viol = 0;
  logic        lat_re;
  logic [12:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic        log_re[$];
  logic [12:0] log_addr[$];
  logic [7:0]  log_data[$];
  always @(negedge clk) begin
    if (!rstn) begin
      if (!mem_init) begin
        for (int i = 0; i < 8192; i++) mem[i] = i[7:0];
        mem_init = 1'b1;
      end
      ram_ph = 0;
      bus.ram_ready = 1'b1;
      bus.ram_data_read = 8'h00;
    end else if (bus.ram_start) begin
      if (!bus.ram_ready || ram_ph != 0) ram_viol++;
      lat_re    = bus.ram_re;
      lat_addr  = bus.ram_address;
      lat_wdata = bus.ram_data_write;
      log_re.push_back(lat_re);
      log_addr.push_back(lat_addr);
      log_data.push_back(lat_re ? 8'h00 : lat_wdata);
      $display("ram %s addr=%04h wdata=%02h", lat_re ? "rd" : "wr", lat_addr, lat_wdata);
      if (!lat_re) mem[lat_addr] = lat_wdata;
      ram_ph = 1;
      bus.ram_ready = 1'b0;
    end else if (ram_ph != 0) begin
      if (bus.ram_address != lat_addr || bus.ram_re != lat_re || bus.ram_data_write != lat_wdata)
        ram_viol++;
      ram_ph++;
      if (ram_ph == 5) begin
        bus.ram_data_read = mem[lat_addr];
        bus.ram_ready = 1'b1;
        ram_ph = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] arg);
    logic [31:0] a;
    a = arg;
    send_byte(cmd);
    for (int k = 0; k < 4; k++) begin
      send_byte(a[31:24]);
      a = a << 8;
    end
  endtask

  task automatic expect_reply(input string tag, input logic [31:0] exp);
    int cyc;
    logic [31:0] w;
    cyc = 0;
    while (tx_q.size() < 4 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (tx_q.size() < 4) begin
      check_eq({tag, "_bytes"}, 32'(tx_q.size()), 32'd4);
      tx_q.delete();
      return;
    end
    w = {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
    repeat (4) void'(tx_q.pop_front());
    $display("reply %s: %08h", tag, w);
    check_eq(tag, w, exp);
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [31:0] arg,
                         input logic [31:0] exp);
    send_frame(cmd, arg);
    expect_reply(tag, exp);
    wait_idle(tag);
  endtask

  task automatic check_acc(input string tag, input int idx, input logic re,
                           input logic [12:0] addr, input logic [7:0] data);
    if (idx < log_re.size())
      check_eq(tag, {7'h0, log_re[idx], 3'h0, log_addr[idx], log_data[idx]},
               {7'h0, re, 3'h0, addr, data});
    else
      check_eq({tag, "_missing"}, 32'(log_re.size()), 32'(idx + 1));
  endtask

  initial begin
    int base;
    int cyc;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {8'h0, bus.tx_start, bus.ram_start, bus.ram_re, busy, status,
                          bus.tx_data, bus.ram_data_write}, 32'h0);
    check_eq("rst_addr", 32'(bus.ram_address), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Single-word write then read back
    send_frame(8'h01, 32'h10);
    check_eq("busy_rise", 32'(busy), 32'd1);
    expect_reply("addr", 32'h10);
    wait_idle("addr");
    run_cmd("load", 8'h02, 32'hA5, 32'hA5);
    run_cmd("write", 8'h03, 32'h0, 32'h3);
    run_cmd("read_req", 8'h05, 32'h0, 32'h5);
    run_cmd("read", 8'h04, 32'h0, 32'hA5);
    check_eq("t1_nacc", 32'(log_re.size()), 32'd2);
    check_acc("t1_wr", 0, 1'b0, 13'h0010, 8'hA5);
    check_acc("t1_rd", 1, 1'b1, 13'h0010, 8'h00);

    // Burst fill wrapping across the top of the address space
    run_cmd("mode1", 8'h0A, 32'h1, 32'h1);
    run_cmd("addr_top", 8'h01, 32'h1FFF, 32'h1FFF);
    run_cmd("load3c", 8'h02, 32'h3C, 32'h3C);
    run_cmd("fill3", 8'h09, 32'h3, 32'h3);
    check_acc("fill_w0", 2, 1'b0, 13'h1FFF, 8'h3C);
    check_acc("fill_w1", 3, 1'b0, 13'h0000, 8'h3C);
    check_acc("fill_w2", 4, 1'b0, 13'h0001, 8'h3C);
    check_eq("fill_nacc", 32'(log_re.size()), 32'd5);
    check_eq("fill_addr", 32'(bus.ram_address), 32'h2);

    // Burst read of 4 words, then an empty burst
    run_cmd("addr100", 8'h01, 32'h100, 32'h100);
    send_frame(8'h08, 32'h4);
    for (int k = 0; k < 4; k++) expect_reply("br4_word", 32'(k));
    wait_idle("br4");
    for (int k = 0; k < 4; k++) check_acc("br4_acc", 5 + k, 1'b1, 13'(32'h100 + k), 8'h00);
    run_cmd("br0", 8'h08, 32'h0, 32'h0);
    check_eq("br0_nacc", 32'(log_re.size()), 32'd9);
    check_eq("br_addr", 32'(bus.ram_address), 32'h104);

    // Frame timeout, then a byte landing exactly on the expiry cycle
    send_byte(8'h06);
    send_byte(8'h00);
    repeat (FT + 1) @(negedge clk);
    run_cmd("count0", 8'h06, 32'h0, 32'h0);
    run_cmd("status_to", 8'h0B, 32'h0, 32'hA);
    run_cmd("status_clr", 8'h0B, 32'h0, 32'h8);
    send_byte(8'h7E);
    repeat (FT - 1) @(negedge clk);
    run_cmd("count_expiry", 8'h06, 32'h0, 32'h1);
    run_cmd("status_to2", 8'h0B, 32'h0, 32'hA);

    // Frame sent during an 8-word burst is dropped
    run_cmd("addr200", 8'h01, 32'h200, 32'h200);
    base = log_re.size();
    send_frame(8'h08, 32'h8);
    send_frame(8'h06, 32'h0);
    for (int k = 0; k < 8; k++) expect_reply("br8_word", 32'(k));
    wait_idle("br8");
    check_eq("br8_nacc", 32'(log_re.size() - base), 32'd8);
    run_cmd("status_ovr", 8'h0B, 32'h0, 32'h9);
    run_cmd("unknown", 8'h7F, 32'h0, 32'h7F);
    run_cmd("status_unk", 8'h0B, 32'h0, 32'hC);
    run_cmd("count2", 8'h06, 32'h0, 32'h2);

    // Reset during RAM_WAIT
    send_frame(8'h05, 32'h0);
    cyc = 0;
    while (!bus.ram_start && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_start_seen", 32'(bus.ram_start), 32'd1);
    @(negedge clk);
    #1;
    check_eq("pre_rst_re", 32'(bus.ram_re), 32'd1);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_outs", {8'h0, bus.tx_start, bus.ram_start, bus.ram_re, busy, status,
                              bus.tx_data, bus.ram_data_write}, 32'h0);
    check_eq("mid_rst_addr", 32'(bus.ram_address), 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_cmd("count_rst", 8'h06, 32'h0, 32'h0);

    check_eq("tx_protocol", 32'(tx_viol), 32'd0);
    check_eq("ram_protocol", 32'(ram_viol), 32'd0);
    check_eq("tx_leftover", 32'(tx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
